compare_window_gen: RTL and testbench

- Parametrised successor to the team's fixed 11-bit equality comparator.
- Contains a free-running position counter and NUM_CH channels. Each channel has a loadable start and end compare register.
- Produces registered match pulses and start/end window levels.
- Drives VGA timing: hsync, hblank, vsync and active-area windows from one counter per axis.

---
 rtl/compare_window_gen.sv | 120 ++++++++++++
 tb/tb_compare_window_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_window_gen.sv
// Purpose: free-running position counter with NUM_CH start/end compare channels (VGA sync/blank windows).
// Latency: match pulses, wrap and window levels are registered one cycle after the counter value that caused them.
// Backpressure: none; en stalls the counter and compares, and register loads are accepted every cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   en                       advance counter and qualify compares
//   load_we/ch/sel/value     write a channel's start (sel=0) or end (sel=1) register
//   period_we/period_value   write terminal count; the counter wraps after reaching it
//   count, wrap              current position, registered one-cycle wrap pulse
//   match_start/match_end    per-channel registered equality pulses
//   window                   per-channel level, high from start match until end match
// Optional macro COMPARE_STICKY_EN adds sticky_clr/sticky: per-channel start-match flag, set wins over clear.
module compare_window_gen #(
    parameter int WIDTH  = 11,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_we,
    input  logic [CH_W-1:0]   load_ch,
    input  logic              load_sel,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              period_we,
    input  logic [WIDTH-1:0]  period_value,
`ifdef COMPARE_STICKY_EN
    input  logic [NUM_CH-1:0] sticky_clr,
    output logic [NUM_CH-1:0] sticky,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              wrap,
    output logic [NUM_CH-1:0] match_start,
    output logic [NUM_CH-1:0] match_end,
    output logic [NUM_CH-1:0] window
);

    logic [WIDTH-1:0]  start_reg [NUM_CH];
    logic [WIDTH-1:0]  end_reg   [NUM_CH];
    logic [WIDTH-1:0]  period;
    logic [NUM_CH-1:0] hit_start;
    logic [NUM_CH-1:0] hit_end;

    // Compares see the register contents before any load landing this cycle.
    always_comb begin
        hit_start = '0;
        hit_end   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_start[i] = en && (count == start_reg[i]);
            hit_end[i]   = en && (count == end_reg[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            wrap        <= 1'b0;
            period      <= '1;
            match_start <= '0;
            match_end   <= '0;
            window      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                start_reg[i] <= '0;
                end_reg[i]   <= '0;
            end
        end else begin
            // >= rather than == so a period lowered below the current count
            // wraps on the next advance instead of running to all-ones.
            if (en) begin
                if (count >= period) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                    wrap  <= 1'b0;
                end
            end else begin
                wrap <= 1'b0;
            end

            if (period_we) begin
                period <= period_value;
            end

            match_start <= hit_start;
            match_end   <= hit_end;

            for (int i = 0; i < NUM_CH; i++) begin
                // End is tested first so start==end never opens the window.
                if (hit_end[i]) begin
                    window[i] <= 1'b0;
                end else if (hit_start[i]) begin
                    window[i] <= 1'b1;
                end

                // Channel numbers at or above NUM_CH match no i and are dropped.
                if (load_we && (load_ch == CH_W'(i))) begin
                    if (load_sel) begin
                        end_reg[i] <= load_value;
                    end else begin
                        start_reg[i] <= load_value;
                    end
                end
            end
        end
    end

`ifdef COMPARE_STICKY_EN
    // Set is applied after clear so a coincident start match keeps the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | hit_start;
        end
    end
`endif

endmodule

// File: tb/tb_compare_window_gen.sv
module tb_compare_window_gen;

    localparam int W  = 11;
    localparam int NC = 5;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          load_we;
    logic [CW-1:0] load_ch;
    logic          load_sel;
    logic [W-1:0]  load_value;
    logic          period_we;
    logic [W-1:0]  period_value;
    logic [W-1:0]  count;
    logic          wrap;
    logic [NC-1:0] match_start;
    logic [NC-1:0] match_end;
    logic [NC-1:0] window;
`ifdef COMPARE_STICKY_EN
    logic [NC-1:0] sticky_clr;
    logic [NC-1:0] sticky;
`endif

    int n_checks;
    int n_fail;

    // Reference model state
    logic [W-1:0]  m_cnt;
    logic          m_wrap;
    logic [W-1:0]  m_per;
    logic [NC-1:0] m_ms;
    logic [NC-1:0] m_me;
    logic [NC-1:0] m_win;
    logic [NC-1:0] m_sticky;
    logic [W-1:0]  m_start_r [NC];
    logic [W-1:0]  m_end_r   [NC];

    compare_window_gen #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load_we      (load_we),
        .load_ch      (load_ch),
        .load_sel     (load_sel),
        .load_value   (load_value),
        .period_we    (period_we),
        .period_value (period_value),
`ifdef COMPARE_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky       (sticky),
`endif
        .count        (count),
        .wrap         (wrap),
        .match_start  (match_start),
        .match_end    (match_end),
        .window       (window)
    );

    always #5 clk = ~clk;

    // Advance one clock: update the model from the rules using pre-edge
    // inputs, then sample the DUT 1 time unit after the rising edge.
    task automatic tick();
        logic [NC-1:0] clr;
        clr = '0;
`ifdef COMPARE_STICKY_EN
        clr = sticky_clr;
`endif
        if (rst) begin
            m_cnt = '0; m_wrap = 0; m_per = '1;
            m_ms = '0; m_me = '0; m_win = '0; m_sticky = '0;
            for (int i = 0; i < NC; i++) begin
                m_start_r[i] = '0;
                m_end_r[i]   = '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                m_ms[i] = en && (m_cnt == m_start_r[i]);
                m_me[i] = en && (m_cnt == m_end_r[i]);
                if (m_me[i])      m_win[i] = 1'b0;
                else if (m_ms[i]) m_win[i] = 1'b1;
            end
            m_sticky = (m_sticky & ~clr) | m_ms;
            if (en) begin
                m_wrap = (m_cnt >= m_per);
                m_cnt  = m_wrap ? '0 : m_cnt + 1'b1;
            end else begin
                m_wrap = 1'b0;
            end
            if (load_we && int'(load_ch) < NC) begin
                if (load_sel) m_end_r[load_ch]   = load_value;
                else          m_start_r[load_ch] = load_value;
            end
            if (period_we) m_per = period_value;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int ch, input logic sel, input int val);
        en = 0; load_we = 1; load_ch = CW'(ch); load_sel = sel; load_value = W'(val);
        tick();
        load_we = 0;
    endtask

    task automatic set_period(input int val);
        en = 0; period_we = 1; period_value = W'(val);
        tick();
        period_we = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_checks++; if (match_start !== '0) begin n_fail++; $display("FAIL reset_ms: got %b want 0", match_start); end
        n_checks++; if (match_end !== '0) begin n_fail++; $display("FAIL reset_me: got %b want 0", match_end); end
        n_checks++; if (window !== '0) begin n_fail++; $display("FAIL reset_window: got %b want 0", window); end
    endtask

    task automatic test_count();
        set_period(799);
        en = 1;
        for (int k = 1; k <= 1600; k++) begin
            tick();
            n_checks++;
            if (count !== W'(k % 800) || wrap !== (k % 800 == 0)) begin
                n_fail++;
                $display("FAIL count_seq k=%0d: got count=%0d wrap=%b want count=%0d wrap=%b",
                         k, count, wrap, k % 800, (k % 800 == 0));
            end
        end
        en = 0;
    endtask

    task automatic test_hsync();
        int ms_n, ms_at, me_at, hi;
        logic win_at_me;
        ms_n = 0; ms_at = -1; me_at = -1; hi = 0; win_at_me = 1'bx;
        do_load(0, 0, 656);
        do_load(0, 1, 752);
        en = 1;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (match_start[0]) begin ms_n++; ms_at = int'(count); end
            if (match_end[0]) begin me_at = int'(count); win_at_me = window[0]; end
            if (window[0]) hi++;
        end
        en = 0;
        n_checks++; if (ms_n !== 1) begin n_fail++; $display("FAIL hsync_ms_count: got %0d want 1", ms_n); end
        n_checks++; if (ms_at !== 657) begin n_fail++; $display("FAIL hsync_ms_pos: got count %0d want 657", ms_at); end
        n_checks++; if (hi !== 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", hi); end
        n_checks++; if (me_at !== 753) begin n_fail++; $display("FAIL hsync_me_pos: got count %0d want 753", me_at); end
        n_checks++; if (win_at_me !== 1'b0) begin n_fail++; $display("FAIL hsync_fall: got %b want 0", win_at_me); end
    endtask

    task automatic test_wrap_span();
        int run, maxrun, hi2, ms2, me2;
        run = 0; maxrun = 0; hi2 = 0; ms2 = 0; me2 = 0;
        do_load(1, 0, 790);
        do_load(1, 1, 5);
        do_load(2, 0, 100);
        do_load(2, 1, 100);
        en = 1;
        for (int k = 0; k < 1600; k++) begin
            tick();
            if (window[1]) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
            if (window[2]) hi2++;
            if (match_start[2]) ms2++;
            if (match_end[2]) me2++;
        end
        if (run > maxrun) maxrun = run;
        en = 0;
        n_checks++; if (maxrun !== 15) begin n_fail++; $display("FAIL wrap_span_width: got %0d want 15", maxrun); end
        n_checks++; if (hi2 !== 0) begin n_fail++; $display("FAIL eq_window: got %0d high cycles want 0", hi2); end
        n_checks++; if (ms2 !== 2) begin n_fail++; $display("FAIL eq_ms_pulses: got %0d want 2", ms2); end
        n_checks++; if (me2 !== 2) begin n_fail++; $display("FAIL eq_me_pulses: got %0d want 2", me2); end
    endtask

    task automatic test_period_shrink();
        int guard;
        logic [W-1:0]  snap_cnt;
        logic [NC-1:0] snap_win;
        guard = 0;
        en = 1;
        while (count !== W'(500) && guard < 900) begin tick(); guard++; end
        n_checks++; if (count !== W'(500)) begin n_fail++; $display("FAIL shrink_reach: got %0d want 500", count); end
        set_period(100);
        n_checks++; if (count !== W'(500)) begin n_fail++; $display("FAIL shrink_hold: got %0d want 500", count); end
        en = 1;
        tick();
        n_checks++;
        if (count !== '0 || wrap !== 1'b1) begin
            n_fail++; $display("FAIL shrink_wrap: got count=%0d wrap=%b want count=0 wrap=1", count, wrap);
        end
        for (int k = 0; k < 50; k++) tick();
        snap_cnt = count; snap_win = window;
        en = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (count !== snap_cnt || window !== snap_win || wrap !== 1'b0 ||
                match_start !== '0 || match_end !== '0) begin
                n_fail++;
                $display("FAIL en_gate k=%0d: got count=%0d win=%b wrap=%b ms=%b me=%b want count=%0d win=%b no pulses",
                         k, count, window, wrap, match_start, match_end, snap_cnt, snap_win);
            end
        end
        set_period(799);
    endtask

    task automatic test_load_collision();
        int guard;
        do_load(0, 0, 200);
        en = 1; guard = 0;
        while (count !== W'(200) && guard < 1000) begin tick(); guard++; end
        load_we = 1; load_ch = 0; load_sel = 0; load_value = W'(300);
        tick();
        load_we = 0;
        n_checks++; if (match_start[0] !== 1'b1) begin n_fail++; $display("FAIL collide_old: got %b want 1", match_start[0]); end
        guard = 0;
        while (count !== W'(301) && guard < 1000) begin tick(); guard++; end
        n_checks++;
        if (count !== W'(301) || match_start[0] !== 1'b1) begin
            n_fail++; $display("FAIL collide_new: got count=%0d ms0=%b want count=301 ms0=1", count, match_start[0]);
        end
        do_load(5, 0, 50);
        do_load(6, 0, 50);
        do_load(7, 1, 50);
        en = 1; guard = 0;
        while (count !== W'(51) && guard < 1000) begin tick(); guard++; end
        n_checks++;
        if (count !== W'(51) || match_start !== '0 || match_end !== '0) begin
            n_fail++; $display("FAIL bad_ch: got count=%0d ms=%b me=%b want count=51 ms=0 me=0", count, match_start, match_end);
        end
        en = 0;
    endtask

    task automatic test_mid_reset();
        int guard;
        en = 1; guard = 0;
        while (window[0] !== 1'b1 && guard < 1000) begin tick(); guard++; end
        n_checks++; if (window[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_open: got %b want 1", window[0]); end
        rst = 1;
        tick();
        rst = 0; en = 0;
        n_checks++;
        if (count !== '0 || wrap !== 1'b0 || match_start !== '0 || match_end !== '0 || window !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got count=%0d wrap=%b ms=%b me=%b win=%b want all 0",
                     count, wrap, match_start, match_end, window);
        end
    endtask

`ifdef COMPARE_STICKY_EN
    task automatic test_sticky();
        int guard;
        sticky_clr = '0;
        set_period(799);
        do_load(0, 0, 656);
        do_load(0, 1, 752);
        en = 1;
        for (int k = 0; k < 1700; k++) tick();
        n_checks++; if (sticky[0] !== 1'b1) begin n_fail++; $display("FAIL sticky_hold: got %b want 1", sticky[0]); end
        guard = 0;
        while (count !== W'(656) && guard < 1000) begin tick(); guard++; end
        sticky_clr[0] = 1;
        tick();
        n_checks++; if (sticky[0] !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b want 1", sticky[0]); end
        tick();
        sticky_clr[0] = 0;
        n_checks++; if (sticky[0] !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b want 0", sticky[0]); end
        en = 0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            en           = ($urandom_range(0, 9) < 8);
            load_we      = ($urandom_range(0, 9) == 0);
            load_ch      = CW'($urandom_range(0, 7));
            load_sel     = 1'($urandom_range(0, 1));
            load_value   = W'($urandom_range(0, 63));
            period_we    = ($urandom_range(0, 29) == 0);
            period_value = W'($urandom_range(10, 63));
            rst          = ($urandom_range(0, 199) == 0);
`ifdef COMPARE_STICKY_EN
            sticky_clr   = NC'($urandom_range(0, 31)) & NC'($urandom_range(0, 31));
`endif
            tick();
            n_checks++;
            if (count !== m_cnt || wrap !== m_wrap || match_start !== m_ms ||
                match_end !== m_me || window !== m_win) begin
                n_fail++;
                $display("FAIL random c=%0d: got cnt=%0d wrap=%b ms=%b me=%b win=%b want cnt=%0d wrap=%b ms=%b me=%b win=%b",
                         c, count, wrap, match_start, match_end, window, m_cnt, m_wrap, m_ms, m_me, m_win);
            end
`ifdef COMPARE_STICKY_EN
            n_checks++;
            if (sticky !== m_sticky) begin
                n_fail++; $display("FAIL random_sticky c=%0d: got %b want %b", c, sticky, m_sticky);
            end
`endif
        end
        rst = 0; en = 0; load_we = 0; period_we = 0;
    endtask

    initial begin
        clk = 0; rst = 1; en = 0; load_we = 0; load_ch = '0; load_sel = 0;
        load_value = '0; period_we = 0; period_value = '0;
`ifdef COMPARE_STICKY_EN
        sticky_clr = '0;
`endif
        n_checks = 0; n_fail = 0;
        test_reset();
        test_count();
        test_hsync();
        test_wrap_span();
        test_period_shrink();
        test_load_collision();
        test_mid_reset();
`ifdef COMPARE_STICKY_EN
        test_sticky();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
